tri_area_arbiter: RTL and testbench
===================================

# tri_area_arbiter

Round-robin arbiter and sequencer that shares one triangle-area unit among NREQ requesters, such as point-in-triangle testers. Each requester presents three vertices. The arbiter grants one requester at a time, loads its vertices into the area unit, starts it, waits for completion and returns the signed area to the winner with a one-cycle acknowledge. It sits between the geometry clients and the single area datapath.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 11: signed coordinate width.
- AW, 24: signed area width.
- TIMEOUT, 64: WAIT-cycle limit. Used only with the timeout macro.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held high until its ack.
- req_pts  in  NREQ*6*W  per-requester {p1x,p1y,p2x,p2y,p3x,p3y}; requester i in slice i; p1x in the MSBs of the slice.
- ack  out  NREQ  one-hot, one-cycle pulse; result valid for that requester.
- rsp_area  out  AW  signed area; valid while any ack bit is high.
- rsp_id  out  3  index of the acked requester.
- rsp_err  out  1  timeout flag, qualified by ack.
- busy  out  1  high in every state except IDLE.
- au_start  out  1  one-cycle start pulse to the area unit.
- au_pts  out  6*W  operands to the area unit, same packing as one req_pts slice.
- au_done  in  1  area unit completion pulse.
- au_area  in  AW  area unit result; sampled when au_done is high.
- au_abort  out  1  one-cycle abort pulse to the area unit. Tied 0 without the timeout macro.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, grant the first high req at or after pointer ptr, searching upward with wrap from NREQ-1 to 0.
  - Latch that requester's slice into au_pts, record its index, go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - au_start=1 for exactly this cycle; go to WAIT.
  - au_done is ignored in ISSUE.
- WAIT:
  - On au_done, capture au_area, clear the error flag, go to RESP.
- RESP:
  - ack[grant]=1, rsp_id=grant, rsp_area=captured value.
  - ptr becomes (grant+1) mod NREQ; go to IDLE.
- au_pts stays stable from ISSUE until the next grant. Operands are not re-sampled if req_pts changes after the grant.
- Requester rules:
  - A requester that drops req after being granted still receives ack and the result.
  - A requester that keeps req high after ack is treated as a new request and competes fairly through the rotated ptr.
- rsp_area is a pass-through of au_area: no sign change, no saturation.
- rsp_area, rsp_id and rsp_err hold their last values between acks. They are valid only while ack is high.
- Reset:
  - Outputs: ack=0, au_start=0, au_abort=0, busy=0, rsp_area=0, rsp_id=0, rsp_err=0, au_pts=0.
  - Internal: ptr=0, state IDLE, timeout counter 0.
- Reset in any state discards the in-flight operation; no ack is issued for it.
- au_done received in IDLE or RESP is ignored.

## Timing
- Request sampled in IDLE at cycle n: au_start at cycle n+1, WAIT from n+2.
- au_done at cycle m (m ≥ n+2): ack at m+1, IDLE at m+2.
- Next grant is possible at m+2.
- Minimum request-to-ack latency with an area unit of latency L (done L cycles after start, L ≥ 1) is L+2 cycles. L=1 gives 3 cycles.
- Back-to-back throughput is one operation per L+3 cycles.
- Fairness: with all requesters continuously requesting, each is served once per NREQ operations.

## Configuration
- TRI_ARB_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT-1 without au_done, the next cycle asserts au_abort for one cycle and enters RESP.
  - In that RESP, ack is high with rsp_err=1 and rsp_area=0.
  - au_done arriving in that same last cycle wins: normal result, rsp_err=0.
- TRI_ARB_TIMEOUT_EN not defined:
  - WAIT lasts indefinitely.
  - No counter logic; rsp_err and au_abort are constant 0.

## Test plan
- Single request: req=4'b0001, pts (0,0),(4,0),(0,4); area model returns 16 after L=1 → au_start at n+1, ack=4'b0001 at n+3, rsp_area=16, rsp_id=0, rsp_err=0.
- Simultaneous requests: req=4'b0110 with ptr=0 → requester 1 served first, then 2; ack pulses 4 cycles apart at L=1; ptr ends at 3.
- Fairness: req=4'b1111 held for 8 operations → ack order 0,1,2,3,0,1,2,3; no requester is served twice in a row.
- Negative area: model returns -24'sd5 → rsp_area=24'hFFFFFB unchanged.
- Reset mid-WAIT: rst pulsed during WAIT → the following cycle shows busy=0, no ack, ptr=0; a subsequent au_done produces no ack; a new req=4'b1000 is served normally.
- Timeout (macro on, TIMEOUT=8): model never asserts done → au_abort one cycle after the 8th WAIT cycle, then ack with rsp_err=1 and rsp_area=0. With the macro off, busy stays high until done.

Source files
------------

// File: rtl/tri_area_arbiter.sv
// Round-robin arbiter sharing one triangle-area unit among NREQ requesters.
// Latency: request to ack is L+2 cycles for an area unit of latency L; one op per L+3 cycles.
// Backpressure: req is held until ack; TRI_ARB_TIMEOUT_EN adds a WAIT watchdog with abort.
module tri_area_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 11,
    parameter int AW      = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*6*W-1:0]    req_pts,
    output logic [NREQ-1:0]        ack,
    output logic [AW-1:0]          rsp_area,
    output logic [2:0]             rsp_id,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   au_start,
    output logic [6*W-1:0]         au_pts,
    input  logic                   au_done,
    input  logic [AW-1:0]          au_area,
    output logic                   au_abort
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = 6 * W;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [IW:0]   idx;
    logic [IW-1:0] ptr_nxt;

`ifdef TRI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] tmo_cnt;
`endif

    // First asserted request at or after ptr, wrapping past NREQ-1.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ))
                idx = idx - (IW+1)'(NREQ);
            if (!pick_vld && req[idx[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[IW-1:0];
            end
        end
    end

    assign ptr_nxt = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant    <= '0;
            ack      <= '0;
            rsp_area <= '0;
            rsp_id   <= '0;
            busy     <= 1'b0;
            au_start <= 1'b0;
            au_pts   <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
            rsp_err  <= 1'b0;
            au_abort <= 1'b0;
            tmo_cnt  <= '0;
`endif
        end else begin
            ack      <= '0;
            au_start <= 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
            au_abort <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick;
                        au_pts   <= req_pts[pick*PW +: PW];
                        au_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef TRI_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done in the final watchdog cycle still delivers a normal result.
                    if (au_done) begin
                        rsp_area <= au_area;
                        rsp_id   <= 3'(grant);
                        ack      <= ONE << grant;
`ifdef TRI_ARB_TIMEOUT_EN
                        rsp_err  <= 1'b0;
`endif
                        state    <= S_RESP;
                    end
`ifdef TRI_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_area <= '0;
                        rsp_id   <= 3'(grant);
                        ack      <= ONE << grant;
                        rsp_err  <= 1'b1;
                        au_abort <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    ptr   <= ptr_nxt;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef TRI_ARB_TIMEOUT_EN
    assign rsp_err  = 1'b0;
    assign au_abort = 1'b0;
`endif

endmodule

// File: tb/tb_tri_area_arbiter.sv
// Directed bench for tri_area_arbiter; the area unit is played by the stimulus with latency 1.
module tb_tri_area_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 11;
    localparam int AW   = 24;
    localparam int PW   = 6 * W;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*PW-1:0]  req_pts;
    logic [NREQ-1:0]     ack;
    logic [AW-1:0]       rsp_area;
    logic [2:0]          rsp_id;
    logic                rsp_err;
    logic                busy;
    logic                au_start;
    logic [PW-1:0]       au_pts;
    logic                au_done;
    logic [AW-1:0]       au_area;
    logic                au_abort;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] pts_tab [NREQ];

    tri_area_arbiter #(.NREQ(NREQ), .W(W), .AW(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_pts(req_pts),
        .ack(ack), .rsp_area(rsp_area), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .au_start(au_start), .au_pts(au_pts),
        .au_done(au_done), .au_area(au_area), .au_abort(au_abort)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int ax, ay, bx, by, cx, cy);
        return {W'(ax), W'(ay), W'(bx), W'(by), W'(cx), W'(cy)};
    endfunction

    // Caller drives req just before the sampling edge; ends at the negedge with the arbiter back in IDLE.
    task automatic run_op(input int id, input logic [AW-1:0] area, input logic [PW-1:0] exp_pts,
                          input bit drop, input bit scramble);
        logic [NREQ-1:0] ea;
        ea     = '0;
        ea[id] = 1'b1;
        tick;
        chk("start_pulse", au_start, 1);
        chk("busy_issue", busy, 1);
        chk("au_pts", au_pts, exp_pts);
        chk("no_early_ack", ack, 0);
        if (scramble)
            req_pts[id*PW +: PW] = ~req_pts[id*PW +: PW];
        tick;
        chk("start_single", au_start, 0);
        au_done = 1'b1;
        au_area = area;
        tick;
        au_done = 1'b0;
        au_area = '0;
        chk("ack", ack, ea);
        chk("rsp_id", rsp_id, id);
        chk("rsp_area", rsp_area, area);
        chk("rsp_err", rsp_err, 0);
        chk("pts_stable", au_pts, exp_pts);
        if (drop)
            req[id] = 1'b0;
        tick;
        chk("ack_drop", ack, 0);
        chk("busy_idle", busy, 0);
        chk("rsp_hold", rsp_area, area);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_pts = '0;
        au_done = 1'b0;
        au_area = '0;
        repeat (2) tick;
        chk("rst_ack", ack, 0);
        chk("rst_start", au_start, 0);
        chk("rst_abort", au_abort, 0);
        chk("rst_busy", busy, 0);
        chk("rst_area", rsp_area, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_pts", au_pts, 0);
        rst = 1'b0;
        tick;

        // Single request, (0,0),(4,0),(0,4) -> 16; operands changed after grant must not leak.
        req_pts[0*PW +: PW] = pk(0, 0, 4, 0, 0, 4);
        req = 4'b0001;
        run_op(0, 24'd16, pk(0, 0, 4, 0, 0, 4), 1'b1, 1'b1);

        // Simultaneous requests from ptr=0, then ptr=3 proven by 4'b1001 picking 3.
        rst = 1'b1; tick; rst = 1'b0;
        req_pts[1*PW +: PW] = pk(1, 1, 5, 1, 1, 7);
        req_pts[2*PW +: PW] = pk(-3, 2, 2, -1, 0, 4);
        req_pts[3*PW +: PW] = pk(0, 0, 0, 3, 2, 0);
        req_pts[0*PW +: PW] = pk(7, 7, 9, 7, 7, 8);
        req = 4'b0110;
        run_op(1, 24'd24, pk(1, 1, 5, 1, 1, 7), 1'b1, 1'b0);
        run_op(2, 24'd19, pk(-3, 2, 2, -1, 0, 4), 1'b1, 1'b0);
        req = 4'b1001;
        run_op(3, 24'hFFFFFB, pk(0, 0, 0, 3, 2, 0), 1'b1, 1'b0);
        chk("neg_area_held", rsp_area, 24'hFFFFFB);
        run_op(0, 24'd2, pk(7, 7, 9, 7, 7, 8), 1'b1, 1'b0);

        // Fairness: all four requesting for 8 ops after reset.
        rst = 1'b1; tick; rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pts_tab[k] = pk(k, k + 1, k + 2, -k, 3 * k, 5);
            req_pts[k*PW +: PW] = pts_tab[k];
        end
        req = 4'b1111;
        for (int i = 0; i < 8; i++)
            run_op(i % NREQ, AW'(100 + i), pts_tab[i % NREQ], 1'b0, 1'b0);
        req = 4'b0000;

        // Reset during WAIT: ptr moved to 2 first, then in-flight op for 2 is discarded.
        req = 4'b0010;
        run_op(1, 24'd40, pts_tab[1], 1'b1, 1'b0);
        req = 4'b0100;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req = 4'b0000;
        chk("rstw_busy", busy, 0);
        chk("rstw_ack", ack, 0);
        chk("rstw_area", rsp_area, 0);
        au_done = 1'b1;
        au_area = 24'd77;
        tick;
        au_done = 1'b0;
        chk("stray_done_ack", ack, 0);
        tick;
        chk("stray_done_ack2", ack, 0);
        chk("stray_done_busy", busy, 0);
        req = 4'b1001;
        run_op(0, 24'd9, pts_tab[0], 1'b1, 1'b0);
        run_op(3, 24'd11, pts_tab[3], 1'b1, 1'b0);

`ifdef TRI_ARB_TIMEOUT_EN
        // Watchdog of 8 WAIT cycles, then abort together with the error ack.
        req = 4'b0100;
        tick;
        chk("to_start", au_start, 1);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("to_no_abort", au_abort, 0);
            chk("to_no_ack", ack, 0);
        end
        tick;
        chk("to_abort", au_abort, 1);
        chk("to_ack", ack, 4'b0100);
        chk("to_err", rsp_err, 1);
        chk("to_area", rsp_area, 0);
        chk("to_id", rsp_id, 2);
        req = 4'b0000;
        tick;
        chk("to_abort_drop", au_abort, 0);
        chk("to_busy", busy, 0);
        // Done in the last watchdog cycle wins.
        req = 4'b0010;
        tick;
        repeat (8) tick;
        au_done = 1'b1;
        au_area = 24'd7;
        tick;
        au_done = 1'b0;
        req = 4'b0000;
        chk("late_ack", ack, 4'b0010);
        chk("late_err", rsp_err, 0);
        chk("late_area", rsp_area, 7);
        chk("late_abort", au_abort, 0);
        tick;
`else
        // Without the watchdog WAIT holds until done.
        req = 4'b0100;
        tick;
        chk("nw_start", au_start, 1);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("nw_busy", busy, 1);
            chk("nw_no_ack", ack, 0);
            chk("nw_abort", au_abort, 0);
        end
        au_done = 1'b1;
        au_area = 24'd5;
        tick;
        au_done = 1'b0;
        req = 4'b0000;
        chk("nw_ack", ack, 4'b0100);
        chk("nw_err", rsp_err, 0);
        chk("nw_area", rsp_area, 5);
        tick;
        chk("nw_idle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
